// File: rtl/div_iter_unit.sv
// div_iter_unit: multi-cycle non-restoring RV32M divider (DIV/DIVU/REM/REMU); optional DIV_FAST_ZERO_EN
module div_iter_unit #(
  parameter int DATA_WIDTH      = 32,
  parameter int STEPS_PER_CYCLE = 2,
  parameter int TAG_WIDTH       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic [TAG_WIDTH-1:0]  tag_in,
  input  logic                  kill,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  tag_out
);
  localparam int N   = DATA_WIDTH;
  localparam int CYC = DATA_WIDTH / STEPS_PER_CYCLE;
  localparam int CW  = $clog2(CYC + 1);
  localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
  logic [1:0]    state;
  logic [N:0]    a, m, a_n;
  logic [N-1:0]  q, q_n, q_f, r_f, rem, abs_d, abs_v;
  logic [CW-1:0] cnt;
  logic          is_rem, neg_q, neg_r, sgn, fast_zero;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign sgn       = ~op[0];
  assign abs_d     = sgn && dividend[N-1] ? -dividend : dividend;
  assign abs_v     = sgn && divisor[N-1] ? -divisor : divisor;
`ifdef DIV_FAST_ZERO_EN
  assign fast_zero = divisor == '0;
`else
  assign fast_zero = 1'b0;
`endif
  assign rem = a[N] ? a[N-1:0] + m[N-1:0] : a[N-1:0];
  assign q_f = neg_q ? -q : q;
  assign r_f = neg_r ? -rem : rem;
  // chained non-restoring steps; add/sub chosen by the sign of A before the shift
  always_comb begin
    a_n = a;
    q_n = q;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      a_n = a_n[N] ? {a_n[N-1:0], q_n[N-1]} + m : {a_n[N-1:0], q_n[N-1]} - m;
      q_n = {q_n[N-2:0], ~a_n[N]};
    end
  end
  // control FSM and datapath registers; kill beats accept and out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a       <= '0;
      q       <= '0;
      m       <= '0;
      cnt     <= '0;
      is_rem  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
      tag_out <= '0;
    end else if (kill) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          is_rem  <= op[1];
          tag_out <= tag_in;
          neg_q   <= sgn && divisor != '0 && (dividend[N-1] ^ divisor[N-1]);
          neg_r   <= sgn && dividend[N-1];
          a       <= '0;
          q       <= abs_d;
          m       <= {1'b0, abs_v};
          cnt     <= CW'(CYC);
          state   <= fast_zero ? DONE : CALC;
          if (fast_zero) result <= op[1] ? dividend : '1;
        end
        CALC: begin
          a     <= a_n;
          q     <= q_n;
          cnt   <= cnt - CW'(1);
          state <= cnt == CW'(1) ? FIX : CALC;
        end
        FIX: begin
          result <= is_rem ? r_f : q_f;
          state  <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter_unit.sv
// tb_div_iter_unit: scoreboard bench for div_iter_unit at default parameters
module tb_div_iter_unit;
  logic        clk = 0, rst = 1, in_valid = 0, kill = 0, out_ready = 0;
  logic        in_ready, out_valid;
  logic [1:0]  op = 0;
  logic [31:0] dividend = 0, divisor = 0, result;
  logic [4:0]  tag_in = 0, tag_out;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed { logic [31:0] res; logic [4:0] tag; } exp_t;
  exp_t sb[$];
`ifdef DIV_FAST_ZERO_EN
  localparam int LZ = 1;
`else
  localparam int LZ = 18;
`endif
  localparam int LF = 18;

  div_iter_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .dividend(dividend), .divisor(divisor), .tag_in(tag_in), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
      return o[1] ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
    end
    return o[1] ? a % b : a / b;
  endfunction

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] t, input logic [31:0] e, input int le, input int hold);
    exp_t x;
    int lat;
    sb.push_back('{res: e, tag: t});
    @(negedge clk);
    op = o; dividend = a; divisor = b; tag_in = t; in_valid = 1;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 0; op = 2'($urandom); dividend = $urandom; divisor = $urandom; tag_in = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(le));
    x = sb.pop_front();
    for (int k = 0; k <= hold; k++) begin
      chk("result", result, x.res);
      chk("tag_out", 32'(tag_out), 32'(x.tag));
      if (k < hold) begin
        chk("in_ready_hold", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("out_valid_hold", 32'(out_valid), 32'd1);
      end
    end
    @(negedge clk);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  o;
    logic [31:0] a, b;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_tag", 32'(tag_out), 32'd0);
    @(negedge clk);
    rst = 0;
    run(2'b01, 100, 7, 5'd1, 32'd14, LF, 0);
    run(2'b11, 100, 7, 5'd2, 32'd2, LF, 0);
    run(2'b00, -32'sd7, 2, 5'd3, 32'hFFFF_FFFD, LF, 0);
    run(2'b10, -32'sd7, 2, 5'd4, 32'hFFFF_FFFF, LF, 0);
    run(2'b10, 7, -32'sd2, 5'd5, 32'd1, LF, 0);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, LF, 0);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h0, LF, 0);
    run(2'b00, 32'h1234_5678, 0, 5'd8, 32'hFFFF_FFFF, LZ, 0);
    run(2'b10, 32'h1234_5678, 0, 5'd9, 32'h1234_5678, LZ, 0);
    run(2'b01, 32'hFFFF_FFFF, 32'h0000_0003, 5'd10, 32'h5555_5555, LF, 4);
    // kill mid-operation, plus a request presented together with kill
    @(negedge clk);
    op = 2'b01; dividend = 100; divisor = 3; tag_in = 5'd20; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    kill = 1; in_valid = 1;
    @(posedge clk); #1;
    chk("kill_in_ready", 32'(in_ready), 32'd1);
    chk("kill_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("kill_beats_accept", 32'(in_ready), 32'd1);
    kill = 0; in_valid = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("kill_no_valid", 32'(out_valid), 32'd0);
    run(2'b01, 9, 3, 5'd12, 32'd3, LF, 0);
    for (int i = 0; i < 16; i++) begin
      o = 2'($urandom);
      a = (i % 4 == 0) ? 32'h8000_0000 : $urandom;
      b = (i % 5 == 0) ? 32'h0 : (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (i % 7 == 0) b = -32'sd1;
      run(o, a, b, 5'(i + 13), model(o, a, b), b == 0 ? LZ : LF, 0);
    end
    // reset mid-CALC clears everything
    @(negedge clk);
    op = 2'b00; dividend = 1000; divisor = 7; tag_in = 5'd30; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_tag", 32'(tag_out), 32'd0);
    rst = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
